// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding request/response
// handshake to instruction memory and presents one fetched word at a time to decode.
module fetch_unit #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCplus4,
  output logic             misalign,
  output logic [WIDTH-1:0] fetch_count
);

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_VALID
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] target;

  // Both sums wrap modulo 2^WIDTH by construction of the operand widths.
  assign target = PCsrc ? (pc_q + ImmOp) : (pc_q + FOUR);

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    req_d   = req_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    count_d = count_q;

    unique case (state_q)
      S_REQ: begin
        // req_q rises on the first edge after reset; the handshake only counts once
        // the request is actually visible on the port.
        req_d = 1'b1;
        if (req_q && imem_ready) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          pc_d    = {target[WIDTH-1:2], 2'b00};
          mis_d   = mis_q | (target[1:0] != 2'b00);
          count_d = count_q + ONE;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // NOTE: only plain flops live here, so every one gets an async reset value;
  // there is no storage array that would need to be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      count_q <= count_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign PC          = pc_q;
  assign PCplus4     = pc_q + FOUR;
  assign misalign    = mis_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model of where the current
// instruction is (idle / requested / presented) predicts every output each cycle.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] ImmOp = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCplus4;
  logic        misalign;
  logic [31:0] fetch_count;

  fetch_unit #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .PC          (PC),
    .PCplus4     (PCplus4),
    .misalign    (misalign),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the instruction is either not yet requested, outstanding at
  // memory, or presented to decode. m_fresh marks the edge right after reset.
  bit          m_out, m_pres, m_fresh, m_mis;
  logic [31:0] m_pc, m_cnt, m_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_pres = 0; m_fresh = 1; m_mis = 0;
    m_pc = RESET_PC; m_cnt = 0; m_instr = 0;
  endtask

  task automatic check_outputs();
    check("instr_valid", instr_valid, m_pres);
    check("pc", PC, m_pc);
    check("pcplus4", PCplus4, m_pc + 32'd4);
    check("fetch_count", fetch_count, m_cnt);
    check("misalign", misalign, m_mis);
    check("imem_req", imem_req, rst_n && !m_out && !m_pres && !m_fresh);
    if (rst_n && !m_out && !m_pres && !m_fresh) check("imem_addr", imem_addr, m_pc);
    if (m_pres) check("instr", instr, m_instr);
    if (!rst_n) check("instr_rst", instr, 32'h0);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check after it.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic st, input logic ps, input logic [31:0] imm);
    logic [31:0] tgt;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    stall = st; PCsrc = ps; ImmOp = imm;
    @(posedge clk);
    if (rst_n) begin
      if (m_pres) begin
        if (!st) begin
          tgt = ps ? m_pc + imm : m_pc + 32'd4;
          if (tgt % 4 != 0) m_mis = 1;
          m_pc   = tgt - (tgt % 4);
          m_cnt  = m_cnt + 1;
          m_pres = 0;
        end
      end else if (m_out) begin
        if (rv) begin
          m_out = 0; m_pres = 1; m_instr = rd;
        end
      end else if (m_fresh) begin
        m_fresh = 0;
      end else if (rdy) begin
        m_out = 1;
      end
    end
    #1;
    check_outputs();
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // One complete instruction: request wait, response latency, stall cycles, retire.
  task automatic run_instr(input int rdy_wait, input int lat, input int stalls,
                           input logic ps, input logic [31:0] imm, output int cycles);
    int k;
    int guard;
    cycles = 0; guard = 0; k = 0;
    while (!m_out && !m_pres && guard < 40) begin
      step(k >= rdy_wait, rbit(), $urandom, rbit(), rbit(), $urandom);
      k++; guard++; cycles++;
    end
    k = 0;
    while (m_out && guard < 40) begin
      step(rbit(), k >= lat, $urandom, rbit(), rbit(), $urandom);
      k++; guard++; cycles++;
    end
    k = 0;
    while (m_pres && guard < 40) begin
      if (k < stalls) step(rbit(), rbit(), $urandom, 1'b1, rbit(), $urandom);
      else            step(rbit(), rbit(), $urandom, 1'b0, ps, imm);
      k++; guard++; cycles++;
    end
    check("progress", guard < 40, 1);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0:       return ($urandom_range(0, 63) - 32) * 4;
      1:       return $urandom & 32'hFFFF_FFFC;
      2:       return $urandom;
      default: return 32'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    int cyc;
    logic [31:0] saved_cnt;
    model_reset();

    // Power-on reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_outputs();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b1;

    // Back-to-back sequential fetches: 0,4,8,C with 3-cycle throughput.
    for (int i = 0; i < 4; i++) begin
      run_instr(0, 0, 0, 1'b0, '0, cyc);
      check("throughput", cyc, (i == 0) ? 4 : 3);
    end
    check("seq_count", fetch_count, 32'd4);
    check("seq_pc", PC, 32'h10);

    // Backward branch from 0x10, with PCsrc toggling during stall cycles.
    run_instr(0, 0, 3, 1'b1, 32'hFFFF_FFF8, cyc);
    check("branch_pc", PC, 32'h8);
    check("branch_mis", misalign, 1'b0);

    // Long stall: nothing moves, then a single sequential retire.
    saved_cnt = fetch_count;
    run_instr(0, 0, 5, 1'b0, '0, cyc);
    check("stall_pc", PC, 32'hC);
    check("stall_cnt", fetch_count, saved_cnt + 1);

    // Wait states on both sides of the handshake.
    run_instr(3, 3, 0, 1'b0, '0, cyc);
    check("wait_pc", PC, 32'h10);

    // Wrap through the top of the address space, then misaligned branch.
    run_instr(0, 0, 0, 1'b1, 32'hFFFF_FFEC, cyc);
    check("top_pc", PC, 32'hFFFF_FFFC);
    run_instr(0, 0, 0, 1'b0, '0, cyc);
    check("wrap_pc", PC, 32'h0);
    run_instr(0, 0, 0, 1'b1, 32'h20, cyc);
    run_instr(0, 1, 0, 1'b1, 32'h6, cyc);
    check("mis_pc", PC, 32'h24);
    check("mis_set", misalign, 1'b1);
    run_instr(0, 0, 0, 1'b0, '0, cyc);
    check("mis_sticky", misalign, 1'b1);

    // Reset while a request is outstanding; a late response must be dropped.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check("in_wait", m_out, 1);
    async_reset();
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
    check("rst_req", imem_req, 1'b1);
    check("rst_addr", imem_addr, RESET_PC);
    step(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, '0);
    run_instr(0, 0, 0, 1'b0, '0, cyc);
    check("rst_pc", PC, RESET_PC + 32'd4);

    // Randomized traffic with one reset landing at an arbitrary point.
    for (int i = 0; i < 150; i++) begin
      if (i == 75) async_reset();
      run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                rbit(), rand_imm(), cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the control unit. Holds the program counter and issues requests to instruction memory over a request/response handshake. Presents the fetched instruction word to decode (Op, funct3 and funct7 are sliced from `instr` downstream). Consumes PCsrc and ImmOp from decode/extend to select between PC+4 and PC+ImmOp for the next fetch.

Parameters:
WIDTH, 32, address/data width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  high: downstream cannot retire the presented instruction
PCsrc  input  1  1 = next PC is PC+ImmOp, 0 = PC+4; sampled only on retire
ImmOp  input  WIDTH  sign-extended branch/jump offset from extend block
imem_req  output  1  fetch request valid
imem_addr  output  WIDTH  fetch address (= PC while imem_req high)
imem_ready  input  1  memory accepts request this cycle when high with imem_req
imem_rvalid  input  1  instruction data valid this cycle
imem_rdata  input  WIDTH  instruction data
instr  output  WIDTH  registered instruction word to decode
instr_valid  output  1  instr holds a valid fetched word
PC  output  WIDTH  address of presented/in-flight instruction
PCplus4  output  WIDTH  PC+4, combinational from PC
misalign  output  1  sticky: a branch target had bits[1:0] != 0
fetch_count  output  WIDTH  count of retired instructions

Behaviour:
- Reset (async, rst_n low): state=S_REQ, PC=RESET_PC, instr=0, instr_valid=0, misalign=0, fetch_count=0, imem_req=0 while rst_n low; all take effect immediately, not on clock edge.
- FSM states S_REQ, S_WAIT, S_VALID:
  - S_REQ: imem_req=1, imem_addr=PC. imem_ready=1 -> S_WAIT. Otherwise stay; hold req and addr stable.
  - S_WAIT: imem_req=0. imem_rvalid=1 -> instr<=imem_rdata, instr_valid<=1, -> S_VALID. Otherwise stay; no timeout.
  - S_VALID: instr_valid=1, instr stable. A retire occurs when stall=0: PC updates, fetch_count<=fetch_count+1, instr_valid<=0, -> S_REQ. stall=1 -> hold everything.
- Next-PC on retire: target = PCsrc ? PC+ImmOp : PC+4. Both sums are modulo 2^WIDTH; wrap is silent, e.g. 0xFFFF_FFFC+4 = 0.
- If target[1:0] != 0: misalign<=1 (sticky until reset), and PC<=target with bits[1:0] cleared.
- PCsrc and ImmOp are ignored in every cycle except a retire cycle.
- imem_rvalid in S_REQ or S_VALID is ignored: no capture, no state change. Stale responses after reset are dropped by this rule.
- Memory protocol: rvalid earliest the cycle after acceptance. One outstanding request max.
- Minimum latency: req accepted cycle n, rvalid n+1, instr_valid high n+2, retire n+2 if stall=0, next req n+3. Peak throughput: 1 instr / 3 cycles.
- fetch_count wraps at 2^WIDTH to 0.
- Reset mid-operation (any state, any cycle phase) returns to reset values. The first request after release uses RESET_PC on the first rising edge with rst_n high.

Test Plan:
1. Reset, RESET_PC=0, memory ready=1, 1-cycle rvalid, stall=0, PCsrc=0 -> imem_addr sequence 0,4,8,C; instr_valid pulses once per 3 cycles; fetch_count=4 after 4 retires.
2. Branch: at PC=0x10 with PCsrc=1, ImmOp=0xFFFF_FFF8 on retire -> next imem_addr=0x08, misalign=0. PCsrc=1 while not retiring -> no effect.
3. Stall: stall=1 for 5 cycles in S_VALID -> instr, PC and instr_valid unchanged; no imem_req; fetch_count unchanged. Release -> single retire, PC+4.
4. Wait states: imem_ready low 3 cycles, then rvalid 4 cycles after accept -> imem_addr stable throughout; correct instr captured; spurious rvalid in S_REQ not captured.
5. Misalign/wrap: PC=0xFFFF_FFFC, PCsrc=0 -> next PC=0. PCsrc=1, ImmOp=6 at PC=0x20 -> PC=0x24, misalign=1 and stays 1.
6. Reset mid-fetch: assert rst_n low in S_WAIT -> outputs reset immediately. Late rvalid after release ignored; first request at RESET_PC.
